// File: rtl/data_memory_responder_if.sv
// ============================================================================
// Module      : data_memory_responder_if
// Description : Block-transfer bus between data-cache controller and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_memory_responder_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int BLOCK_WIDTH = 128
);
  logic                   READ;
  logic                   WRITE;
  logic [ADDR_WIDTH-1:0]  ADDRESS;
  logic [BLOCK_WIDTH-1:0] WRITEDATA;
  logic [BLOCK_WIDTH-1:0] READDATA;
  logic                   BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

`default_nettype wire

// File: rtl/data_memory_responder.sv
// ============================================================================
// Module      : data_memory_responder
// Description : Fixed-latency block memory answering cache line fills and
//               write-backs. Optional macro DATA_MEM_CLEAR_ON_RESET_EN makes
//               RESET also zero the whole array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int BLOCK_WIDTH = 128,
  parameter int LATENCY     = 5
) (
  input  wire                     CLK,
  input  wire                     RESET,
  data_memory_responder_if.slave  bus
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam int c_CNT_W = $clog2(LATENCY) + 1;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("data_memory_responder: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_op_write;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic [c_CNT_W-1:0]     r_count;
  logic [BLOCK_WIDTH-1:0] r_readdata;
  logic [BLOCK_WIDTH-1:0] r_mem [c_DEPTH];

  logic                   w_busywait;
  logic                   w_capture;
  logic                   w_access;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_readdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        // WRITE wins when both requests are raised together.
        r_op_write <= bus.WRITE;
        r_addr     <= bus.ADDRESS;
        r_wdata    <= bus.WRITEDATA;
        r_count    <= c_CNT_W'(LATENCY - 1);
      end else if (r_state == S_BUSY && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
      if (w_access && !r_op_write) begin
        r_readdata <= r_mem[r_addr];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busywait  = 1'b0;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.READ || bus.WRITE) begin
          w_busywait  = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_busywait = 1'b1;
        if (r_count == '0) begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef DATA_MEM_CLEAR_ON_RESET_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_access && r_op_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end
`else
  // A reset landing on the final BUSY edge must still drop the pending write.
  always_ff @(posedge CLK) begin
    if (!RESET && w_access && r_op_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

`ifndef SYNTHESIS
  initial begin
    for (int i = 0; i < c_DEPTH; i++) begin
      r_mem[i] = '0;
    end
  end
`endif
`endif

  assign bus.READDATA = r_readdata;
  assign bus.BUSYWAIT = w_busywait;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Randomised scoreboard bench for data_memory_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

  localparam int c_AW  = 6;
  localparam int c_BW  = 128;
  localparam int c_LAT = 5;

  logic CLK;
  logic RESET;

  data_memory_responder_if #(.ADDR_WIDTH(c_AW), .BLOCK_WIDTH(c_BW)) bus ();

  data_memory_responder #(
    .ADDR_WIDTH (c_AW),
    .BLOCK_WIDTH(c_BW),
    .LATENCY    (c_LAT)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a plain array of blocks plus the last value read out.
  logic [c_BW-1:0] model_mem [2**c_AW];
  logic [c_BW-1:0] model_rd;
  logic [c_BW-1:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [c_BW-1:0] act, input logic [c_BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    model_rd = '0;
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 2**c_AW; i++) model_mem[i] = '0;
`endif
  endtask

  // Monitor: measures each stall run and scores the DONE cycle against the queue.
  initial begin
    int run;
    logic [c_BW-1:0] last_rd;
    logic [c_BW-1:0] exp;
    run     = 0;
    last_rd = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        run     = 0;
        last_rd = '0;
      end else if (bus.BUSYWAIT) begin
        run++;
        chk("readdata_hold_during_busy", bus.READDATA, last_rd);
      end else if (run != 0) begin
        chk("busywait_run_length", c_BW'(run), c_BW'(c_LAT + 1));
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          chk("readdata_at_done", bus.READDATA, exp);
          last_rd = exp;
        end
        run = 0;
      end
    end
  end

  task automatic xact(input bit rd, input bit wr, input logic [c_AW-1:0] a,
                      input logic [c_BW-1:0] d, input bit chg);
    bit done;
    if (wr) begin
      model_mem[a] = d;
      exp_q.push_back(model_rd);
    end else begin
      model_rd = model_mem[a];
      exp_q.push_back(model_rd);
    end
    @(posedge CLK); #1;
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = d;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (chg && i == 2) begin
        bus.ADDRESS   = a ^ 6'h01;
        bus.WRITEDATA = ~d;
      end
      if (!bus.BUSYWAIT) done = 1'b1;
    end
    if (!done) chk("transaction_timeout", 0, 1);
    bus.READ = 1'b0; bus.WRITE = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("busywait_after_reset", c_BW'(bus.BUSYWAIT), '0);
    chk("readdata_after_reset", bus.READDATA, '0);
  endtask

  // Write whose third BUSY cycle is cut short by RESET; nothing is committed.
  task automatic abort_write(input logic [c_AW-1:0] a, input logic [c_BW-1:0] d);
    @(posedge CLK); #1;
    bus.WRITE = 1'b1; bus.ADDRESS = a; bus.WRITEDATA = d;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1; bus.WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("busywait_after_abort", c_BW'(bus.BUSYWAIT), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [c_BW-1:0] d;
    for (int i = 0; i < 2**c_AW; i++) model_mem[i] = '0;
    model_rd      = '0;
    RESET         = 1'b1;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = '0;
    bus.WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset_busywait", c_BW'(bus.BUSYWAIT), '0);
    chk("reset_readdata", bus.READDATA, '0);

    xact(1, 0, 6'h03, '0, 0);
    xact(0, 1, 6'h0A, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0);
    xact(1, 0, 6'h0A, '0, 0);
    xact(1, 1, 6'h01, 128'h1111, 0);
    xact(1, 0, 6'h01, '0, 0);
    abort_write(6'h02, 128'h5555);
    xact(1, 0, 6'h02, '0, 0);
    xact(0, 1, 6'h0B, 128'h0B0B, 0);
    xact(1, 0, 6'h0A, '0, 1);
    xact(0, 1, 6'h3F, 128'hFF, 0);
    pulse_reset();
    xact(1, 0, 6'h3F, '0, 0);

    for (int n = 0; n < 60; n++) begin
      bit rd, wr;
      int op;
      op = $urandom_range(3);
      rd = (op != 1);
      wr = (op != 0);
      d  = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(2)) @(posedge CLK);
      xact(rd, wr, c_AW'($urandom_range(2**c_AW - 1)), d, ($urandom_range(3) == 0));
    end

    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", c_BW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
